// File: rtl/sub_out_capture_fifo.sv
// Capture FIFO for the Sub stage output bundle: packs each strobed sample into an
// 11-bit record and buffers it in a show-ahead FIFO with overflow accounting.
module sub_out_capture_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_dotnamed,
   input  logic [2:0]    a_NO,
   input  logic [3:0]    f4_dotnamed,
   input  logic [1:0]    bign2_dotnamed,
   input  logic          dtmp_NO,
   input  logic          etmp_dotnamed,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [10:0]   out_data,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [7:0]    drop_cnt,
   input  logic          ovf_clr
);

   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   logic [10:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [7:0]    r_drop_cnt;

   logic [10:0]   w_record;
   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_drop;

   assign w_record  = {a_NO, f4_dotnamed, bign2_dotnamed, dtmp_NO, etmp_dotnamed};
   assign w_full    = (r_count == L_DEPTH);
   assign w_pop     = out_valid & out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok = c_dotnamed & (~w_full | w_pop);
   assign w_drop    = c_dotnamed & w_full & ~w_pop;

   // Record storage, intentionally without reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_record;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

   // Overflow flag and saturating drop counter; a drop outranks a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (ovf_clr) begin
            r_drop_cnt <= 8'd1;
         end else if (r_drop_cnt != 8'd255) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end else begin
            r_drop_cnt <= r_drop_cnt;
         end
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_overflow <= r_overflow;
         r_drop_cnt <= r_drop_cnt;
      end
   end

   // Show-ahead head record, zero while empty.
   always_comb begin
      out_valid = (r_count != {(AW+1){1'b0}});
      if (out_valid) begin
         out_data = r_mem[r_rd_ptr];
      end else begin
         out_data = 11'd0;
      end
   end

   assign count    = r_count;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_sub_out_capture_fifo.sv
// Randomized bench for sub_out_capture_fifo against a queue-based reference model.
module tb_sub_out_capture_fifo;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_dotnamed;
   logic [2:0]    a_NO;
   logic [3:0]    f4_dotnamed;
   logic [1:0]    bign2_dotnamed;
   logic          dtmp_NO;
   logic          etmp_dotnamed;
   logic          out_valid;
   logic          out_ready;
   logic [10:0]   out_data;
   logic [AW:0]   count;
   logic          overflow;
   logic [7:0]    drop_cnt;
   logic          ovf_clr;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] m_q[$];
   bit          m_ovf;
   int          m_drop;

   sub_out_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .c_dotnamed(c_dotnamed), .a_NO(a_NO),
      .f4_dotnamed(f4_dotnamed), .bign2_dotnamed(bign2_dotnamed),
      .dtmp_NO(dtmp_NO), .etmp_dotnamed(etmp_dotnamed),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [10:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : 11'd0;
      chk({tag, ".valid"}, {31'd0, out_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
      chk({tag, ".data"},  {21'd0, out_data}, {21'd0, exp_data});
      chk({tag, ".count"}, {29'd0, count}, m_q.size());
      chk({tag, ".ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
      chk({tag, ".drops"}, {24'd0, drop_cnt}, m_drop);
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input string tag, input bit c, input logic [10:0] rec,
                        input bit rdy, input bit clr);
      bit pop, drop;
      c_dotnamed     = c;
      a_NO           = rec[10:8];
      f4_dotnamed    = rec[7:4];
      bign2_dotnamed = rec[3:2];
      dtmp_NO        = rec[1];
      etmp_dotnamed  = rec[0];
      out_ready      = rdy;
      ovf_clr        = clr;
      pop  = (m_q.size() != 0) && rdy;
      drop = c && (m_q.size() == DEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (c && !drop) m_q.push_back(rec);
      if (drop) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2*DEPTH && m_q.size() != 0; i++) cycle(tag, 1'b0, 11'd0, 1'b1, 1'b0);
      chk({tag, ".empty"}, {29'd0, count}, 32'd0);
   endtask

   initial begin
      logic [10:0] rec;
      rst = 1'b1; c_dotnamed = 1'b0; a_NO = 3'd0; f4_dotnamed = 4'd0; bign2_dotnamed = 2'd0;
      dtmp_NO = 1'b0; etmp_dotnamed = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      m_ovf = 1'b0; m_drop = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk_all("reset");

      // Single record, held while not ready
      rec = {3'd5, 4'hA, 2'd2, 1'b1, 1'b0};
      cycle("t1.push", 1'b1, rec, 1'b0, 1'b0);
      chk("t1.lit", {21'd0, out_data}, 32'h5AA);
      for (int i = 0; i < 3; i++) cycle("t1.hold", 1'b0, 11'd0, 1'b0, 1'b0);
      drain("t1.drain");

      // Fill, drop one, drain in order
      for (int i = 0; i < 4; i++) begin
         rec = {i[2:0], 8'd0};
         cycle("t2.fill", 1'b1, rec, 1'b0, 1'b0);
      end
      cycle("t2.drop", 1'b1, 11'h7FF, 1'b0, 1'b0);
      chk("t2.drop_lit", {24'd0, drop_cnt}, 32'd1);
      drain("t2.drain");

      // Full with simultaneous push/pop, then wrap-around pairs
      for (int i = 0; i < 4; i++) cycle("t3.fill", 1'b1, 11'($urandom), 1'b0, 1'b0);
      cycle("t3.pp", 1'b1, 11'h123, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle("t3.wrap", 1'b1, 11'($urandom), 1'b1, 1'b0);
      drain("t3.drain");

      // Saturating drop counter and clear priority
      for (int i = 0; i < 4; i++) cycle("t4.fill", 1'b1, 11'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) cycle("t4.sat", 1'b1, 11'($urandom), 1'b0, 1'b0);
      chk("t4.sat_lit", {24'd0, drop_cnt}, 32'd255);
      cycle("t4.clr", 1'b0, 11'd0, 1'b0, 1'b1);
      cycle("t4.clrdrop", 1'b1, 11'h055, 1'b0, 1'b1);
      chk("t4.clrdrop_lit", {24'd0, drop_cnt}, 32'd1);
      drain("t4.drain");

      // Pop request on empty
      for (int i = 0; i < 3; i++) cycle("t5.empty", 1'b0, 11'd0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle("rand", ($urandom_range(0, 3) != 0), 11'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      drain("rand.drain");

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) cycle("t6.fill", 1'b1, 11'($urandom), 1'b0, 1'b0);
      cycle("t6.pop", 1'b0, 11'd0, 1'b1, 1'b0);
      chk("t6.pre_cnt", {29'd0, count}, 32'd3);
      #2 rst = 1'b1;
      #1;
      m_q.delete(); m_ovf = 1'b0; m_drop = 0;
      chk_all("t6.rst");
      #1 rst = 1'b0;
      @(posedge clk); #1;
      cycle("t6.push", 1'b1, 11'h2C3, 1'b0, 1'b0);
      chk("t6.rec", {21'd0, out_data}, 32'h2C3);
      drain("t6.drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
